// File: rtl/bus_pkg.sv
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and width helpers for the bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWNED  = 2'd1,
        RESUME = 2'd2
    } arb_state_t;

    // Width of a master index; a single master still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin pick of the first eligible master
//               at or above rr_ptr, wrapping back to index 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
    import bus_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    localparam int GW          = id_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] eligible,
    input  logic [GW-1:0]          rr_ptr,
    output logic                   valid,
    output logic [GW-1:0]          winner
);

    int w_dist;
    int w_best;

    // Distance from the pointer (modulo NUM_MASTERS) ranks the candidates.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_dist = 0;
        w_best = NUM_MASTERS;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            w_dist = (j >= int'(rr_ptr)) ? (j - int'(rr_ptr))
                                         : (j + NUM_MASTERS - int'(rr_ptr));
            if (eligible[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                winner = GW'(j);
                valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin bus arbiter with split-transaction parking and
//               per-tenancy hold limit. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int MAX_HOLD    = 64,
    localparam int GW          = id_width(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   split,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [GW-1:0]          grant_id,
    output logic                   bus_busy,
    output logic                   split_pending,
    output logic                   timeout
);

    localparam int c_hold_w = cnt_width(MAX_HOLD);
    localparam logic [c_hold_w-1:0] c_hold_last =
        (MAX_HOLD > 0) ? c_hold_w'(MAX_HOLD - 1) : '0;

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [GW-1:0]          r_split_owner;
    logic [GW-1:0]          w_split_owner_nxt;
    logic [GW-1:0]          r_rr_ptr;
    logic [GW-1:0]          w_rr_ptr_nxt;
    logic [c_hold_w-1:0]    r_hold_cnt;
    logic [c_hold_w-1:0]    w_hold_nxt;
    logic [NUM_MASTERS-1:0] r_mask;
    logic [NUM_MASTERS-1:0] w_mask_nxt;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [NUM_MASTERS-1:0] w_parked;
    logic [NUM_MASTERS-1:0] w_eligible;
    logic [GW-1:0]          w_grant_id_nxt;
    logic [GW-1:0]          w_win;
    logic                   w_win_valid;
    logic                   w_split_pending_nxt;
    logic                   w_timeout_nxt;
    logic                   r_split_d;
    logic                   w_split_rise;
    logic                   w_hold_expired;
    logic                   w_owner_req;
    logic                   w_so_req;

    always_comb begin
        w_parked = '0;
        if (split_pending) begin
            w_parked[r_split_owner] = 1'b1;
        end
    end

    assign w_eligible     = req & ~w_parked & ~r_mask;
    assign w_owner_req    = req[grant_id];
    assign w_so_req       = req[r_split_owner];
    assign w_split_rise   = split & ~r_split_d;
    assign w_hold_expired = (MAX_HOLD != 0) && (r_hold_cnt == c_hold_last);

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_picker (
        .eligible (w_eligible),
        .rr_ptr   (r_rr_ptr),
        .valid    (w_win_valid),
        .winner   (w_win)
    );

    always_comb begin
        w_state_nxt         = r_state;
        w_grant_nxt         = grant;
        w_grant_id_nxt      = grant_id;
        w_split_pending_nxt = split_pending;
        w_split_owner_nxt   = r_split_owner;
        w_rr_ptr_nxt        = r_rr_ptr;
        w_hold_nxt          = '0;
        w_mask_nxt          = r_mask & req;
        w_timeout_nxt       = 1'b0;

        // A parked master that gives up its request abandons the split.
        if (split_pending && !w_so_req) begin
            w_split_pending_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                w_grant_nxt    = '0;
                w_grant_id_nxt = '0;
                if (split_pending && !split && w_so_req) begin
                    w_grant_nxt[r_split_owner] = 1'b1;
                    w_grant_id_nxt      = r_split_owner;
                    w_split_pending_nxt = 1'b0;
                    w_state_nxt         = OWNED;
                end else if (w_win_valid) begin
                    w_grant_nxt[w_win] = 1'b1;
                    w_grant_id_nxt     = w_win;
                    w_rr_ptr_nxt       = (w_win == GW'(NUM_MASTERS - 1)) ? '0
                                                                         : w_win + GW'(1);
                    w_state_nxt        = OWNED;
                end
            end

            OWNED: begin
                w_hold_nxt = r_hold_cnt + c_hold_w'(1);
                if (!w_owner_req) begin
                    w_grant_nxt    = '0;
                    w_grant_id_nxt = '0;
                    w_hold_nxt     = '0;
                    w_state_nxt    = (split_pending && !split && w_so_req) ? RESUME : IDLE;
                end else if (w_split_rise && !split_pending) begin
                    w_split_owner_nxt   = grant_id;
                    w_split_pending_nxt = 1'b1;
                    w_grant_nxt         = '0;
                    w_grant_id_nxt      = '0;
                    w_hold_nxt          = '0;
                    w_state_nxt         = IDLE;
                end else if (w_hold_expired) begin
                    w_mask_nxt[grant_id] = 1'b1;
                    w_timeout_nxt        = 1'b1;
                    w_grant_nxt          = '0;
                    w_grant_id_nxt       = '0;
                    w_hold_nxt           = '0;
                    w_state_nxt          = IDLE;
                end
            end

            RESUME: begin
                w_grant_nxt    = '0;
                w_grant_id_nxt = '0;
                if (w_so_req) begin
                    w_grant_nxt[r_split_owner] = 1'b1;
                    w_grant_id_nxt      = r_split_owner;
                    w_split_pending_nxt = 1'b0;
                    w_state_nxt         = OWNED;
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_grant_nxt    = '0;
                w_grant_id_nxt = '0;
                w_state_nxt    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            grant         <= '0;
            grant_id      <= '0;
            bus_busy      <= 1'b0;
            split_pending <= 1'b0;
            timeout       <= 1'b0;
            r_split_owner <= '0;
            r_rr_ptr      <= '0;
            r_hold_cnt    <= '0;
            r_mask        <= '0;
            r_split_d     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            grant         <= w_grant_nxt;
            grant_id      <= w_grant_id_nxt;
            bus_busy      <= |w_grant_nxt;
            split_pending <= w_split_pending_nxt;
            timeout       <= w_timeout_nxt;
            r_split_owner <= w_split_owner_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_mask        <= w_mask_nxt;
            r_split_d     <= split;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed self-checking bench for bus_arbiter (2 masters,
//               hold limit of 8 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic       split;
    logic [1:0] grant;
    logic [0:0] grant_id;
    logic       bus_busy;
    logic       split_pending;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_MASTERS (2),
        .MAX_HOLD    (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .split         (split),
        .grant         (grant),
        .grant_id      (grant_id),
        .bus_busy      (bus_busy),
        .split_pending (split_pending),
        .timeout       (timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; split = 1'b0;
        step(); step();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id: got %b want 0", grant_id); end
        checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset_bus_busy: got %b want 0", bus_busy); end
        checks++; if (split_pending !== 1'b0) begin errors++; $display("FAIL reset_split_pending: got %b want 0", split_pending); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        rst = 1'b0;
        step();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL idle_no_req: got %b want 00", grant); end
    endtask

    task automatic test_basic();
        req = 2'b01;
        step();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL basic_grant0: got %b want 01", grant); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL basic_id0: got %b want 0", grant_id); end
        checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", bus_busy); end
        req = 2'b11;
        step();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL basic_hold_a: got %b want 01", grant); end
        step();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL basic_hold_b: got %b want 01", grant); end
        req = 2'b10;
        step();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL basic_idle_gap: got %b want 00", grant); end
        checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL basic_gap_busy: got %b want 0", bus_busy); end
        step();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL basic_grant1: got %b want 10", grant); end
        checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL basic_id1: got %b want 1", grant_id); end
        req = 2'b00;
        step(); step();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL basic_release: got %b want 00", grant); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        req = 2'b11;
        step();
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (grant !== exp) begin errors++; $display("FAIL fair_grant[%0d]: got %b want %b", i, grant, exp); end
            step(); step();
            req = 2'b11 & ~exp;
            step();
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL fair_gap[%0d]: got %b want 00", i, grant); end
            req = 2'b11;
            step();
        end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL fair_grant[4]: got %b want 01", grant); end
        req = 2'b00;
        step(); step();
    endtask

    task automatic test_split();
        req = 2'b01;
        step();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL split_pre_grant: got %b want 01", grant); end
        split = 1'b1;
        step();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL split_release: got %b want 00", grant); end
        checks++; if (split_pending !== 1'b1) begin errors++; $display("FAIL split_pending_set: got %b want 1", split_pending); end
        req = 2'b11;
        step();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL split_other_grant: got %b want 10", grant); end
        split = 1'b0;
        step();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL split_other_hold: got %b want 10", grant); end
        checks++; if (split_pending !== 1'b1) begin errors++; $display("FAIL split_pending_hold: got %b want 1", split_pending); end
        req = 2'b01;
        step();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL split_resume_gap: got %b want 00", grant); end
        step();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL split_resume_grant: got %b want 01", grant); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL split_resume_id: got %b want 0", grant_id); end
        checks++; if (split_pending !== 1'b0) begin errors++; $display("FAIL split_pending_clr: got %b want 0", split_pending); end
        req = 2'b00;
        step(); step();
    endtask

    task automatic test_split_idle();
        req = 2'b01;
        step();
        split = 1'b1;
        step();
        checks++; if (split_pending !== 1'b1) begin errors++; $display("FAIL sidle_parked: got %b want 1", split_pending); end
        split = 1'b0; req = 2'b11;
        step();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sidle_owner_first: got %b want 01", grant); end
        checks++; if (split_pending !== 1'b0) begin errors++; $display("FAIL sidle_pending_clr: got %b want 0", split_pending); end
        req = 2'b10;
        step(); step();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL sidle_then_m1: got %b want 10", grant); end
        req = 2'b00;
        step(); step();
    endtask

    task automatic test_split_abandon();
        req = 2'b01;
        step();
        split = 1'b1;
        step();
        req = 2'b00;
        step();
        checks++; if (split_pending !== 1'b0) begin errors++; $display("FAIL abandon_pending: got %b want 0", split_pending); end
        split = 1'b0;
        step();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abandon_no_regrant: got %b want 00", grant); end
    endtask

    task automatic test_timeout();
        req = 2'b01;
        step();
        req = 2'b11;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            checks++; if (grant !== 2'b01 || timeout !== 1'b0) begin
                errors++; $display("FAIL tmo_hold[%0d]: grant=%b timeout=%b want 01/0", k, grant, timeout);
            end
        end
        step();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tmo_drop: got %b want 00", grant); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b want 1", timeout); end
        step();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_end: got %b want 0", timeout); end
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tmo_m1_grant: got %b want 10", grant); end
        req = 2'b01;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tmo_masked[%0d]: got %b want 00", k, grant); end
        end
        req = 2'b00;
        step();
        req = 2'b01;
        step();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tmo_unmasked: got %b want 01", grant); end
        req = 2'b00;
        step(); step();
    endtask

    task automatic test_async_reset();
        req = 2'b01;
        step();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL arst_pre: got %b want 01", grant); end
        #3 rst = 1'b1;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arst_grant: got %b want 00", grant); end
        checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", bus_busy); end
        step();
        rst = 1'b0;
        step();
        checks++; if (grant !== 2'b01 || grant_id !== 1'b0) begin
            errors++; $display("FAIL arst_resume: grant=%b id=%b want 01/0", grant, grant_id);
        end
        req = 2'b00;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fairness();
        test_split();
        test_split_idle();
        test_split_abandon();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
